// File: rtl/l3_bank_arbiter_pkg.sv
// Shared L3 definitions: bank geometry, core count and sequencer state encoding.
package l3_pkg;

    localparam int unsigned L3_ADDR_W    = 5;
    localparam int unsigned L3_DATA_W    = 32;
    localparam int unsigned L3_NUM_CORES = 6;
    localparam int unsigned L3_ID_W      = 3;

    typedef enum logic [0:0] {
        L3_INIT = 1'b0,
        L3_RUN  = 1'b1
    } l3_state_e;

endpackage

// File: rtl/l3_bank_arbiter_if.sv
// Requester, response and RAM32 signals of one L3 bank sequencer.
interface l3_bank_arbiter_if
    import l3_pkg::*;
#(
    parameter int unsigned NUM_REQ = L3_NUM_CORES,
    parameter int unsigned ADDR_W  = L3_ADDR_W,
    parameter int unsigned DATA_W  = L3_DATA_W,
    parameter int unsigned ID_W    = L3_ID_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_we;
    logic [DATA_W-1:0]         rsp_data;

    logic [ADDR_W-1:0]         ram_a;
    logic [DATA_W-1:0]         ram_d;
    logic                      ram_we;
    logic [DATA_W-1:0]         ram_q;

    logic                      init_done;
    logic [15:0]               grant_cnt;

    // Arbiter side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_q,
        output req_ready, rsp_valid, rsp_id, rsp_we, rsp_data,
        output ram_a, ram_d, ram_we, init_done, grant_cnt
    );

    // Requesters plus RAM side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_q,
        input  req_ready, rsp_valid, rsp_id, rsp_we, rsp_data,
        input  ram_a, ram_d, ram_we, init_done, grant_cnt
    );

endinterface

// File: rtl/l3_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scan starts one past the last winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_grant
);

    // First set request at (ptr+1), (ptr+2), ... modulo NUM_REQ wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l3_bank_arbiter.sv
// L3 RAM32 bank sequencer: zero-scrub after reset, then round-robin single-port access.
module l3_bank_arbiter
    import l3_pkg::*;
#(
    parameter int unsigned NUM_REQ = L3_NUM_CORES,
    parameter int unsigned ADDR_W  = L3_ADDR_W,
    parameter int unsigned DATA_W  = L3_DATA_W,
    parameter int unsigned ID_W    = L3_ID_W
) (
    input  logic            clk,
    input  logic            rst,
    l3_bank_arbiter_if.slave bus
);

    localparam logic [0:0]        ST_INIT   = 1'(L3_INIT);
    localparam logic [0:0]        ST_RUN    = 1'(L3_RUN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]         state;
    logic [0:0]         state_d;
    logic [ADDR_W-1:0]  scrub_cnt;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               any_grant;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    // Only arbitrate in RUN; reset blocks any handshake in the same cycle.
    assign arb_req = (state == ST_RUN && !rst) ? bus.req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (ptr),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    assign win_we    = bus.req_we[winner];
    assign win_addr  = bus.req_addr[32'(winner)*ADDR_W +: ADDR_W];
    assign win_wdata = bus.req_wdata[32'(winner)*DATA_W +: DATA_W];

    // Read data is only meaningful for a read response; everything else returns zero.
    assign bus.rsp_data = (bus.rsp_valid && !bus.rsp_we) ? bus.ram_q : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus same-cycle grant and RAM port drive.
    always_comb begin
        state_d       = state;
        bus.req_ready = '0;
        bus.ram_we    = 1'b0;
        bus.ram_a     = '0;
        bus.ram_d     = '0;
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    bus.ram_we = 1'b1;
                    bus.ram_a  = scrub_cnt;
                    if (scrub_cnt == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    bus.req_ready = grant;
                    if (any_grant) begin
                        bus.ram_we = win_we;
                        bus.ram_a  = win_addr;
                        bus.ram_d  = win_wdata;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Scrub counter, RR pointer, grant counter and the one-cycle response pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_cnt     <= '0;
            ptr           <= ID_W'(NUM_REQ - 1);
            bus.grant_cnt <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_we    <= 1'b0;
            bus.init_done <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                scrub_cnt <= scrub_cnt + ADDR_W'(1);
            end
            bus.init_done <= (state_d == ST_RUN);
            if (any_grant) begin
                ptr           <= winner;
                bus.grant_cnt <= bus.grant_cnt + 16'd1;
            end
            bus.rsp_valid <= any_grant;
            bus.rsp_id    <= any_grant ? winner : '0;
            bus.rsp_we    <= any_grant & win_we;
        end
    end

endmodule

// File: tb/tb_l3_bank_arbiter.sv
// Directed bench for l3_bank_arbiter with a behavioural RAM32 model.
module tb_l3_bank_arbiter;

    localparam int unsigned NR = 6;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 3;

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NR-1:0] exp_ready;
        logic          exp_ram_we;
        logic [AW-1:0] exp_ram_a;
        logic          exp_rsp_valid;
        logic [IW-1:0] exp_rsp_id;
        logic          exp_rsp_we;
        logic [DW-1:0] exp_rsp_data;
        logic [15:0]   exp_cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [DW-1:0] mem [32];
    vec_t tbl [16];

    l3_bank_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

    l3_bank_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM32: synchronous write, Q registered one cycle after A.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hBAD0_0000 | 32'(i);
    end
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
        bus.ram_q <= mem[bus.ram_a];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [NR-1:0] v, input logic [NR-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.req_valid = v;
        bus.req_we    = we;
        for (int i = 0; i < int'(NR); i++) begin
            bus.req_addr[i*AW +: AW]  = addr;
            bus.req_wdata[i*DW +: DW] = wdata;
        end
    endtask

    function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR-1:0] we,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [NR-1:0] rdy, input logic rwe, input logic [AW-1:0] ra,
                                input logic rv, input logic [IW-1:0] rid, input logic rw,
                                input logic [DW-1:0] rd, input logic [15:0] cnt);
        vec_t r;
        r.valid = v; r.we = we; r.addr = a; r.wdata = wd;
        r.exp_ready = rdy; r.exp_ram_we = rwe; r.exp_ram_a = ra;
        r.exp_rsp_valid = rv; r.exp_rsp_id = rid; r.exp_rsp_we = rw;
        r.exp_rsp_data = rd; r.exp_cnt = cnt;
        return r;
    endfunction

    // Two reset cycles, then the 32-cycle scrub; optionally holds core 3 read of addr 7 from mid-scrub.
    task automatic reset_scrub(input bit held);
        @(negedge clk);
        rst = 1'b1;
        set_req('0, '0, '0, '0);
        @(negedge clk); #1;
        chk("rst req_ready", 32'(bus.req_ready), 0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst rsp_id", 32'(bus.rsp_id), 0);
        chk("rst rsp_we", 32'(bus.rsp_we), 0);
        chk("rst rsp_data", bus.rsp_data, 0);
        chk("rst init_done", 32'(bus.init_done), 0);
        chk("rst grant_cnt", 32'(bus.grant_cnt), 0);
        chk("rst ram_we", 32'(bus.ram_we), 0);
        chk("rst ram_a", 32'(bus.ram_a), 0);
        chk("rst ram_d", bus.ram_d, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (held && k == 10) set_req(6'h08, 6'h00, 5'd7, 32'h0);
            #1;
            chk($sformatf("scrub%0d ram_we", k), 32'(bus.ram_we), 1);
            chk($sformatf("scrub%0d ram_a", k), 32'(bus.ram_a), 32'(k));
            chk($sformatf("scrub%0d ram_d", k), bus.ram_d, 0);
            chk($sformatf("scrub%0d req_ready", k), 32'(bus.req_ready), 0);
            chk($sformatf("scrub%0d init_done", k), 32'(bus.init_done), 0);
            @(negedge clk);
        end
        #1;
        chk("run init_done", 32'(bus.init_done), 1);
        chk("run grant_cnt", 32'(bus.grant_cnt), 0);
        if (held) begin
            chk("held req_ready", 32'(bus.req_ready), 32'h08);
            chk("held ram_a", 32'(bus.ram_a), 7);
            chk("held ram_we", 32'(bus.ram_we), 0);
            @(negedge clk);
            set_req('0, '0, '0, '0);
            #1;
            chk("held rsp_valid", 32'(bus.rsp_valid), 1);
            chk("held rsp_id", 32'(bus.rsp_id), 3);
            chk("held rsp_we", 32'(bus.rsp_we), 0);
            chk("held rsp_data", bus.rsp_data, 0);
            chk("held grant_cnt", 32'(bus.grant_cnt), 1);
        end else begin
            chk("run req_ready idle", 32'(bus.req_ready), 0);
        end
    endtask

    initial begin
        int bad_ready;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_req('0, '0, '0, '0);

        //          valid  we     addr  wdata         ready  rwe ra    rv rid rw data          cnt
        tbl[0]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h01, 0, 5'd5,  0, 0, 0, 32'h0,        16'd0);
        tbl[1]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h02, 0, 5'd5,  1, 0, 0, 32'h0,        16'd1);
        tbl[2]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h04, 0, 5'd5,  1, 1, 0, 32'h0,        16'd2);
        tbl[3]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h08, 0, 5'd5,  1, 2, 0, 32'h0,        16'd3);
        tbl[4]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h10, 0, 5'd5,  1, 3, 0, 32'h0,        16'd4);
        tbl[5]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h20, 0, 5'd5,  1, 4, 0, 32'h0,        16'd5);
        tbl[6]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h01, 0, 5'd5,  1, 5, 0, 32'h0,        16'd6);
        tbl[7]  = mk(6'h3F, 6'h00, 5'd5, 32'h0,        6'h02, 0, 5'd5,  1, 0, 0, 32'h0,        16'd7);
        tbl[8]  = mk(6'h04, 6'h04, 5'd31, 32'hDEADBEEF, 6'h04, 1, 5'd31, 1, 1, 0, 32'h0,        16'd8);
        tbl[9]  = mk(6'h10, 6'h00, 5'd31, 32'h0,        6'h10, 0, 5'd31, 1, 2, 1, 32'h0,        16'd9);
        tbl[10] = mk(6'h00, 6'h00, 5'd0, 32'h0,        6'h00, 0, 5'd0,  1, 4, 0, 32'hDEADBEEF, 16'd10);
        tbl[11] = mk(6'h00, 6'h00, 5'd0, 32'h0,        6'h00, 0, 5'd0,  0, 0, 0, 32'h0,        16'd10);
        tbl[12] = mk(6'h21, 6'h00, 5'd3, 32'h0,        6'h20, 0, 5'd3,  0, 0, 0, 32'h0,        16'd10);
        tbl[13] = mk(6'h21, 6'h00, 5'd3, 32'h0,        6'h01, 0, 5'd3,  1, 5, 0, 32'h0,        16'd11);
        tbl[14] = mk(6'h21, 6'h00, 5'd3, 32'h0,        6'h20, 0, 5'd3,  1, 0, 0, 32'h0,        16'd12);
        tbl[15] = mk(6'h00, 6'h00, 5'd0, 32'h0,        6'h00, 0, 5'd0,  1, 5, 0, 32'h0,        16'd13);

        reset_scrub(1'b1);
        reset_scrub(1'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            set_req(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            #1;
            chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_ready));
            chk($sformatf("row%0d ram_we", i), 32'(bus.ram_we), 32'(tbl[i].exp_ram_we));
            chk($sformatf("row%0d ram_a", i), 32'(bus.ram_a), 32'(tbl[i].exp_ram_a));
            chk($sformatf("row%0d ram_d", i), bus.ram_d,
                (tbl[i].exp_ready != '0) ? tbl[i].wdata : 32'h0);
            chk($sformatf("row%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].exp_rsp_valid));
            if (tbl[i].exp_rsp_valid) begin
                chk($sformatf("row%0d rsp_id", i), 32'(bus.rsp_id), 32'(tbl[i].exp_rsp_id));
                chk($sformatf("row%0d rsp_we", i), 32'(bus.rsp_we), 32'(tbl[i].exp_rsp_we));
            end
            chk($sformatf("row%0d rsp_data", i), bus.rsp_data, tbl[i].exp_rsp_data);
            chk($sformatf("row%0d grant_cnt", i), 32'(bus.grant_cnt), 32'(tbl[i].exp_cnt));
        end

        // Core 1 streams alone until the 16-bit grant counter wraps (13 grants already done).
        @(negedge clk);
        set_req(6'h02, 6'h00, 5'd1, 32'h0);
        bad_ready = 0;
        for (int n = 0; n < 65522; n++) begin
            #1;
            if (bus.req_ready !== 6'h02) bad_ready++;
            @(negedge clk);
        end
        chk("stream req_ready misses", 32'(bad_ready), 0);
        #1;
        chk("grant_cnt pre-wrap", 32'(bus.grant_cnt), 32'hFFFF);
        @(negedge clk);
        set_req('0, '0, '0, '0);
        #1;
        chk("grant_cnt wrap", 32'(bus.grant_cnt), 0);

        // Reset lands in the cycle after a read grant.
        @(negedge clk);
        set_req(6'h01, 6'h00, 5'd9, 32'h0);
        #1;
        chk("midrst grant", 32'(bus.req_ready), 32'h01);
        chk("midrst ram_a", 32'(bus.ram_a), 9);
        @(negedge clk);
        rst = 1'b1;
        set_req('0, '0, '0, '0);
        #1;
        chk("midrst rsp_valid during rst", 32'(bus.rsp_valid), 1);
        chk("midrst rsp_id during rst", 32'(bus.rsp_id), 0);
        chk("midrst ram_we during rst", 32'(bus.ram_we), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst rsp_valid after", 32'(bus.rsp_valid), 0);
        chk("midrst init_done", 32'(bus.init_done), 0);
        chk("midrst grant_cnt", 32'(bus.grant_cnt), 0);
        chk("midrst scrub ram_we", 32'(bus.ram_we), 1);
        chk("midrst scrub ram_a0", 32'(bus.ram_a), 0);
        @(negedge clk); #1;
        chk("midrst scrub ram_a1", 32'(bus.ram_a), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l3_bank_arbiter.md
Name: l3_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for one RAM32 bank of the shared central L3 cache.
- Shares the bank's single port between NUM_REQ core requesters (default 6, one per performance core).
- After reset, zero-scrubs all 32 words, then issues at most one access per cycle.
- Returns read data, or a write acknowledge, one cycle after the grant, tagged with the requester id.

Parameters:
NUM_REQ, 6, number of requesters (2..8)
ADDR_W, 5, word address width (RAM32 depth 32)
DATA_W, 32, data width
ID_W, 3, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_we  in  NUM_REQ  per-requester write (1) / read (0)
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i occupies [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant
rsp_valid  out  1  response valid
rsp_id  out  ID_W  index of the responding requester
rsp_we  out  1  response is a write acknowledge
rsp_data  out  DATA_W  read data; 0 for write acks
ram_a  out  ADDR_W  to RAM32 A
ram_d  out  DATA_W  to RAM32 D
ram_we  out  1  to RAM32 WE
ram_q  in  DATA_W  from RAM32 Q; valid the cycle after A is presented
init_done  out  1  high once the scrub has completed
grant_cnt  out  16  count of granted accesses; wraps at 2**16

Behaviour:
- FSM states:
  - INIT: scrub in progress.
  - RUN: normal arbitration.
  - rst forces INIT with scrub counter 0.
- Reset values (rst high):
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_we=0, rsp_data=0, init_done=0, grant_cnt=0.
  - ram_we=0, ram_a=0, ram_d=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
- INIT:
  - Each cycle: ram_we=1, ram_a=cnt, ram_d=0, then cnt++.
  - When cnt=31 is written, the next state is RUN.
  - Takes exactly 32 cycles after rst deasserts; init_done=1 from the 33rd cycle.
  - req_ready=0 throughout; requests are held off, not dropped.
- RUN, arbitration (combinational):
  - Scan req_valid starting at (ptr+1) mod NUM_REQ, wrapping.
  - The first set bit wins; req_ready is one-hot on the winner, or all 0 if there is no valid request.
  - Handshake completes when req_valid[i] & req_ready[i] in the same cycle.
  - A requester holds valid and payload stable until granted.
  - req_ready never depends on anything other than req_valid, ptr and state.
- RUN, issue (same cycle as grant):
  - ram_a = winner's address, ram_we = winner's req_we, ram_d = winner's wdata.
  - With no grant: ram_we=0, ram_a/ram_d hold 0.
- Grant bookkeeping:
  - ptr <= winner on grant; unchanged with no grant.
  - grant_cnt increments on every grant; 0xFFFF wraps to 0.
- Response (one cycle latency):
  - Registered rsp_valid=1, rsp_id=winner, rsp_we=req_we in the cycle after the grant.
  - rsp_data = ram_q when rsp_valid & !rsp_we; otherwise 0.
  - Responses cannot be back-pressured; throughput is one access per cycle.
- Read-after-write: a write granted in cycle N, then a read of the same address granted in cycle N+1, returns the new data (RAM32 write-then-read ordering).
- Single requester streaming: the pointer lands on the same index each time, so it is granted every cycle.
- rst mid-operation: any in-flight response is discarded (rsp_valid=0 in the next cycle) and the scrub restarts from address 0.
- Simultaneous events: rst dominates all other inputs. A request arriving on the last INIT cycle is first eligible in the first RUN cycle.

Decomposition:
- Shared package l3_pkg holds:
  - L3_ADDR_W=5, L3_DATA_W=32, L3_NUM_CORES=6, L3_ID_W=3.
  - State enum {L3_INIT, L3_RUN}.
- One sub-module: rr_arbiter (NUM_REQ). Inputs: req vector and ptr. Outputs: one-hot grant, encoded winner, any_grant. Purely combinational and reusable for the mem_ctrl and uncore banks.

Test Plan:
- Scrub: assert rst 2 cycles, release, no requests -> ram_we=1 with ram_a=0..31 and ram_d=0 for exactly 32 cycles; init_done=1 on cycle 33; grant_cnt=0.
- Held request: req_valid[3]=1 read addr 7 raised during INIT -> req_ready=0 until RUN, granted on the first RUN cycle; next cycle rsp_valid=1, rsp_id=3, rsp_data=0.
- Round-robin: all 6 requesters valid continuously after init -> grant order 0,1,2,3,4,5,0,1; no requester waits more than 5 cycles; grant_cnt=8 after 8 cycles.
- Read-after-write: core 2 writes 0xDEADBEEF to addr 31, then core 4 reads addr 31 in the next cycle -> response 1 is rsp_we=1, rsp_id=2, rsp_data=0; response 2 is rsp_id=4, rsp_data=0xDEADBEEF.
- Counter wrap: force 65536 grants -> grant_cnt wraps to 0.
- Reset mid-read: rst asserted in the cycle after a read grant -> rsp_valid=0 in the next cycle, init_done=0, and the scrub restarts at ram_a=0.
